life_gen_engine: RTL and testbench

//   Sequential Game-of-Life generation engine for the VGA demoscene board.

---
 rtl/life_gen_engine.sv | 167 ++++++++++++++++
 tb/tb_life_gen_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_engine.sv
// Game-of-Life generation engine: two board banks, one cell per clock, bank swap per generation.
module life_gen_engine #(
  parameter int unsigned COLS_LOG2      = 3,
  parameter int unsigned ROWS_LOG2      = 3,
  parameter int unsigned FRAMES_PER_GEN = 60,
  parameter int unsigned WRAP           = 0,
  parameter logic [(2**(COLS_LOG2+ROWS_LOG2))-1:0] SEED = 64'h0000_0000_0000_0E00
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_tick,
  input  logic                            run,
  input  logic                            step_req,
  input  logic                            seed_req,
  input  logic [COLS_LOG2+ROWS_LOG2-1:0]  rd_addr,
  output logic                            rd_data,
  output logic                            busy,
  output logic                            gen_done,
  output logic [15:0]                     generation,
  output logic [COLS_LOG2+ROWS_LOG2:0]    population
);

  localparam int unsigned ADDR_W = COLS_LOG2 + ROWS_LOG2;
  localparam int unsigned POP_W  = ADDR_W + 1;
  localparam int unsigned SIZE   = 2**ADDR_W;
  localparam int unsigned COLS   = 2**COLS_LOG2;
  localparam int unsigned ROWS   = 2**ROWS_LOG2;
  localparam int unsigned FCNT_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_GEN - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_SWAP, ST_SEED} state_t;

  state_t              state_q;
  state_t              state_nx;
  logic [SIZE-1:0]     bank0;
  logic [SIZE-1:0]     bank1;
  logic [SIZE-1:0]     disp_bank;
  logic                disp_sel;
  logic [ADDR_W-1:0]   cell_idx;
  logic [POP_W-1:0]    acc;
  logic [FCNT_W-1:0]   fcnt;
  logic [3:0]          nbr_cnt;
  logic                next_cell;
  logic                trig;
  logic [ROWS_LOG2-1:0] cell_row;
  logic [COLS_LOG2-1:0] cell_col;

  assign disp_bank = disp_sel ? bank1 : bank0;
  assign rd_data   = disp_bank[rd_addr];
  assign cell_row  = cell_idx[ADDR_W-1:COLS_LOG2];
  assign cell_col  = cell_idx[COLS_LOG2-1:0];

  // Generation start: paced by frames when running, by step_req when paused; only from IDLE
  assign trig = (state_q == ST_IDLE) &&
                ((run && frame_tick && (fcnt == FCNT_LAST)) || (!run && step_req));

  // Live-neighbour count of the current cell; power-of-two board makes truncation a modulo
  always_comb begin
    int nr;
    int nc;
    logic [ROWS_LOG2-1:0] wr;
    logic [COLS_LOG2-1:0] wc;
    nbr_cnt = '0;
    nr      = 0;
    nc      = 0;
    wr      = '0;
    wc      = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = int'(cell_row) + dr;
        nc = int'(cell_col) + dc;
        wr = ROWS_LOG2'(nr);
        wc = COLS_LOG2'(nc);
        if ((dr != 0 || dc != 0) &&
            (WRAP != 0 || (nr >= 0 && nr < int'(ROWS) && nc >= 0 && nc < int'(COLS))))
          nbr_cnt = nbr_cnt + 4'(disp_bank[{wr, wc}]);
      end
    end
  end

  // Life rule for the current cell
  assign next_cell = (nbr_cnt == 4'd3) || (disp_bank[cell_idx] && (nbr_cnt == 4'd2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state logic; seed_req overrides everything
  always_comb begin
    state_nx = state_q;
    if (seed_req) begin
      state_nx = ST_SEED;
    end else begin
      case (state_q)
        ST_IDLE: if (trig) state_nx = ST_CALC;
        ST_CALC: if (cell_idx == CELL_LAST) state_nx = ST_SWAP;
        ST_SWAP: state_nx = ST_IDLE;
        ST_SEED: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Frame pacing counter: runs while run=1, held while paused, cleared by seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   fcnt <= '0;
    else if (seed_req)            fcnt <= '0;
    else if (run && frame_tick)   fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + FCNT_W'(1);
  end

  // Banks, cell sweep, population and generation bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0      <= SEED;
      bank1      <= '0;
      disp_sel   <= 1'b0;
      cell_idx   <= '0;
      acc        <= '0;
      generation <= '0;
      population <= '0;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      busy     <= (state_nx != ST_IDLE);
      if (seed_req) begin
        if (disp_sel) begin
          bank1 <= SEED;
          bank0 <= '0;
        end else begin
          bank0 <= SEED;
          bank1 <= '0;
        end
        generation <= '0;
        population <= '0;
        cell_idx   <= '0;
        acc        <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig) begin
              cell_idx <= '0;
              acc      <= '0;
            end
          end
          ST_CALC: begin
            if (disp_sel) bank0[cell_idx] <= next_cell;
            else          bank1[cell_idx] <= next_cell;
            acc      <= acc + POP_W'(next_cell);
            cell_idx <= cell_idx + ADDR_W'(1);
          end
          ST_SWAP: begin
            disp_sel   <= ~disp_sel;
            generation <= generation + 16'd1;
            population <= acc;
            gen_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: four boards in lockstep against a cell-grid reference model.
module tb_life_gen_engine;

  localparam int NI = 4;
  localparam logic [63:0] S_A = 64'h0000_0000_0000_0E00;  // blinker 9,10,11
  localparam logic [63:0] S_B = 64'h0000_0000_0000_0303;  // block 0,1,8,9
  localparam logic [63:0] S_C = 64'h0100_0000_0000_0101;  // blinker 56,0,8 on torus
  localparam logic [63:0] S_D = 64'h3C5A_0F81_7E24_99C3;  // irregular soup on torus
  localparam int FPG = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic run = 1'b0;
  logic step_req = 1'b0;
  logic seed_req = 1'b0;
  logic [5:0] rd_addr = '0;
  logic [NI-1:0] rd_d, busy_o, done_o;
  logic [15:0] gen_o [NI];
  logic [6:0]  pop_o [NI];

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] seeds [NI];
  int          wraps [NI];
  logic [63:0] exp_b [NI];
  int          exp_pop [NI];
  int          exp_gen;
  int          fcnt_m;
  logic [63:0] brd [NI];

  always #5 clk = ~clk;

  life_gen_engine #(.FRAMES_PER_GEN(FPG), .WRAP(0), .SEED(S_A)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step_req(step_req),
    .seed_req(seed_req), .rd_addr(rd_addr), .rd_data(rd_d[0]), .busy(busy_o[0]),
    .gen_done(done_o[0]), .generation(gen_o[0]), .population(pop_o[0]));
  life_gen_engine #(.FRAMES_PER_GEN(FPG), .WRAP(0), .SEED(S_B)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step_req(step_req),
    .seed_req(seed_req), .rd_addr(rd_addr), .rd_data(rd_d[1]), .busy(busy_o[1]),
    .gen_done(done_o[1]), .generation(gen_o[1]), .population(pop_o[1]));
  life_gen_engine #(.FRAMES_PER_GEN(FPG), .WRAP(1), .SEED(S_C)) u_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step_req(step_req),
    .seed_req(seed_req), .rd_addr(rd_addr), .rd_data(rd_d[2]), .busy(busy_o[2]),
    .gen_done(done_o[2]), .generation(gen_o[2]), .population(pop_o[2]));
  life_gen_engine #(.FRAMES_PER_GEN(FPG), .WRAP(1), .SEED(S_D)) u_d (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step_req(step_req),
    .seed_req(seed_req), .rd_addr(rd_addr), .rd_data(rd_d[3]), .busy(busy_o[3]),
    .gen_done(done_o[3]), .generation(gen_o[3]), .population(pop_o[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: one Life generation on an 8x8 grid, counting neighbours cell by cell
  function automatic logic [63:0] next_gen(input logic [63:0] b, input int wrap);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap != 0) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              cnt += int'(b[rr*8+cc]);
          end
        end
        n[r*8+c] = (cnt == 3) || (b[r*8+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  task automatic m_gen();
    for (int i = 0; i < NI; i++) begin
      exp_b[i]   = next_gen(exp_b[i], wraps[i]);
      exp_pop[i] = $countones(exp_b[i]);
    end
    exp_gen = (exp_gen + 1) % 65536;
  endtask

  task automatic m_seed();
    for (int i = 0; i < NI; i++) begin
      exp_b[i]   = seeds[i];
      exp_pop[i] = 0;
    end
    exp_gen = 0;
    fcnt_m  = 0;
  endtask

  task automatic read_boards();
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1;
      for (int i = 0; i < NI; i++) brd[i][a] = rd_d[i];
    end
  endtask

  task automatic check_all(input string tag);
    read_boards();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s board%0d", tag, i), brd[i], exp_b[i]);
      check($sformatf("%s gen%0d", tag, i), 64'(gen_o[i]), 64'(exp_gen));
      check($sformatf("%s pop%0d", tag, i), 64'(pop_o[i]), 64'(exp_pop[i]));
    end
    check({tag, " busy"}, 64'(busy_o), 64'(0));
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done_o[0]) pulses++;
    end
  endtask

  task automatic pulse_step();
    @(negedge clk) step_req = 1'b1;
    @(negedge clk) step_req = 1'b0;
  endtask

  task automatic pulse_seed();
    @(negedge clk) seed_req = 1'b1;
    @(negedge clk) seed_req = 1'b0;
  endtask

  // Step and settle; a generation is expected only while paused
  task automatic do_step(input string tag);
    int p, e;
    e = run ? 0 : 1;
    if (!run) m_gen();
    pulse_step();
    count_done(80, p);
    check({tag, " step pulses"}, 64'(p), 64'(e));
  endtask

  // Frame tick and settle; the model paces generations by counting ticks while running
  task automatic do_tick(input string tag);
    int p, e;
    e = 0;
    if (run) begin
      if (fcnt_m == FPG - 1) begin
        fcnt_m = 0;
        m_gen();
        e = 1;
      end else begin
        fcnt_m++;
      end
    end
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    count_done(80, p);
    check({tag, " tick pulses"}, 64'(p), 64'(e));
  endtask

  initial begin
    int cyc, p, op, nt;
    seeds[0] = S_A; seeds[1] = S_B; seeds[2] = S_C; seeds[3] = S_D;
    wraps[0] = 0;   wraps[1] = 0;   wraps[2] = 1;   wraps[3] = 1;
    m_seed();

    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // First generation: latency, pulse width, known patterns
    @(negedge clk) step_req = 1'b1;
    @(negedge clk) step_req = 1'b0;
    cyc = 1;
    check("busy_in_calc", 64'(busy_o), 64'hF);
    while (!done_o[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("step_latency", 64'(cyc), 64'd66);
    m_gen();
    @(negedge clk);
    check("done_width", 64'(done_o), 64'(0));
    check_all("step1");
    check("blinker_vertical", brd[0], 64'h0000_0000_0004_0404);
    check("block_still", brd[1], S_B);
    check("torus_blinker", brd[2], 64'h0000_0000_0000_0083);

    do_step("step2");
    check_all("step2");
    check("blinker_back", brd[0], S_A);
    do_step("step3");
    check_all("step3");
    check("block_still3", brd[1], S_B);

    // Step during CALC is dropped
    m_gen();
    pulse_step();
    repeat (20) @(negedge clk);
    pulse_step();
    count_done(100, p);
    check("step_in_calc pulses", 64'(p), 64'd1);
    check_all("step_in_calc");

    // Step while running is ignored
    run = 1'b1;
    do_step("step_run");
    check_all("step_run");

    // Free run: six ticks make three generations
    for (int t = 0; t < 6; t++) do_tick("freerun");
    check_all("freerun");

    // seed_req part-way through CALC aborts it
    run = 1'b0;
    pulse_step();
    repeat (19) @(negedge clk);
    pulse_seed();
    m_seed();
    count_done(100, p);
    check("abort pulses", 64'(p), 64'd0);
    check_all("abort");

    // seed_req together with step_req: seed only
    @(negedge clk) begin seed_req = 1'b1; step_req = 1'b1; end
    @(negedge clk) begin seed_req = 1'b0; step_req = 1'b0; end
    m_seed();
    count_done(80, p);
    check("seed_step pulses", 64'(p), 64'd0);
    check_all("seed_step");

    // Randomized sequences of steps, ticks and reseeds
    for (int it = 0; it < 30; it++) begin
      run = 1'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 4));
      if (op <= 1) begin
        do_step("rnd");
      end else if (op <= 3) begin
        nt = int'($urandom_range(1, 3));
        for (int t = 0; t < nt; t++) do_tick("rnd");
      end else begin
        pulse_seed();
        m_seed();
        count_done(5, p);
      end
      check_all($sformatf("rnd%0d", it));
    end

    // Asynchronous reset in the middle of CALC
    run = 1'b0;
    pulse_step();
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_seed();
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check_all("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    do_step("post_rst");
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
